// File: rtl/cache_lookup_cam.sv
// Fully associative key/data lookup store with per-entry valid bits, newest entry at index 0.
// Write/invalidate/flush update the store; lookups are registered with an LREQ/LVALID handshake.
module cache_lookup_cam #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic              INV,
  input  logic              FLUSH,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LREQ,
  input  logic [ADDR_W-1:0] LADDR,
  output logic              LVALID,
  output logic              FOUND,
  output logic [DATA_W-1:0] DOUT,
  output logic [IDX_W-1:0]  HIT_IDX,
  output logic [IDX_W:0]    COUNT,
  output logic              FULL
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] key_q  [DEPTH];
  logic [ADDR_W-1:0] key_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IDX_W:0]    count_q, count_d;

  logic              lvalid_q;
  logic              found_q;
  logic [DATA_W-1:0] dout_q;
  logic [IDX_W-1:0]  hit_idx_q;

  logic [DEPTH-1:0]  w_match, w_sel;
  logic              w_hit;
  logic [DEPTH-1:0]  l_match;
  logic              l_hit;
  logic [IDX_W-1:0]  l_idx;
  logic [DATA_W-1:0] l_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = valid_q[i] && (key_q[i] == ADDR);
      l_match[i] = valid_q[i] && (key_q[i] == LADDR);
    end
  end

  // Lowest index wins if the store ever holds duplicate valid keys.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && !w_hit) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    l_hit  = 1'b0;
    l_idx  = '0;
    l_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (l_match[i] && !l_hit) begin
        l_hit  = 1'b1;
        l_idx  = IDX_W'(i);
        l_data = data_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    count_d = count_q;
    if (FLUSH) begin
      valid_d = '0;
      count_d = '0;
    end else if (INV) begin
      if (w_hit) begin
        valid_d = valid_q & ~w_sel;
        count_d = count_q - (IDX_W+1)'(1);
      end
    end else if (WE) begin
      if (w_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_sel[i]) data_d[i] = DIN;
        end
      end else begin
        // Insert at the front; the oldest slot falls off, costing a count only if it was valid.
        valid_d = {valid_q[DEPTH-2:0], 1'b1};
        for (int i = 1; i < DEPTH; i++) begin
          key_d[i]  = key_q[i-1];
          data_d[i] = data_q[i-1];
        end
        key_d[0]  = ADDR;
        data_d[0] = DIN;
        count_d   = count_q + (IDX_W+1)'(1) - (IDX_W+1)'(valid_q[DEPTH-1]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  // Lookup sees pre-update contents; results hold while no request is made.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lvalid_q  <= 1'b0;
      found_q   <= 1'b0;
      dout_q    <= '0;
      hit_idx_q <= '0;
    end else begin
      lvalid_q <= LREQ;
      if (LREQ) begin
        found_q   <= l_hit;
        dout_q    <= l_data;
        hit_idx_q <= l_idx;
      end
    end
  end

  assign LVALID  = lvalid_q;
  assign FOUND   = found_q;
  assign DOUT    = dout_q;
  assign HIT_IDX = hit_idx_q;
  assign COUNT   = count_q;
  assign FULL    = (count_q == (IDX_W+1)'(DEPTH));

endmodule

// File: tb/tb_cache_lookup_cam.sv
// Randomised and directed bench for cache_lookup_cam (DEPTH=4) against a queue-based model.
module tb_cache_lookup_cam;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE = 1'b0, INV = 1'b0, FLUSH = 1'b0, LREQ = 1'b0;
  logic [31:0] ADDR = '0, DIN = '0, LADDR = '0;
  logic        LVALID, FOUND, FULL;
  logic [31:0] DOUT;
  logic [1:0]  HIT_IDX;
  logic [2:0]  COUNT;

  cache_lookup_cam #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .INV(INV), .FLUSH(FLUSH), .ADDR(ADDR), .DIN(DIN),
    .LREQ(LREQ), .LADDR(LADDR), .LVALID(LVALID), .FOUND(FOUND), .DOUT(DOUT),
    .HIT_IDX(HIT_IDX), .COUNT(COUNT), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [31:0] k;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;

  // e_* : model outputs after the coming edge; exp_* : model outputs now visible.
  logic        e_lvalid, e_found, exp_lvalid, exp_found;
  logic [31:0] e_dout, exp_dout;
  int          e_idx, e_count, exp_idx, exp_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '0;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(z);
    e_lvalid = 0; e_found = 0; e_dout = 0; e_idx = 0; e_count = 0;
    exp_lvalid = 0; exp_found = 0; exp_dout = 0; exp_idx = 0; exp_count = 0;
  endtask

  // Drive one cycle of inputs, advance the model, step past the edge.
  task automatic step(input bit we, input bit inv, input bit flush, input logic [31:0] addr,
                      input logic [31:0] din, input bit lreq, input logic [31:0] laddr);
    int   h;
    ent_t t;
    WE = we; INV = inv; FLUSH = flush; ADDR = addr; DIN = din; LREQ = lreq; LADDR = laddr;
    e_lvalid = lreq;
    if (lreq) begin
      e_found = 0; e_dout = 0; e_idx = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!e_found && mq[i].v && mq[i].k == laddr) begin
          e_found = 1; e_dout = mq[i].d; e_idx = i;
        end
      end
    end
    h = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (mq[i].v && mq[i].k == addr) h = i;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        t = mq[i]; t.v = 0; mq[i] = t;
      end
    end else if (inv) begin
      if (h >= 0) begin
        t = mq[h]; t.v = 0; mq[h] = t;
      end
    end else if (we) begin
      if (h >= 0) begin
        t = mq[h]; t.d = din; mq[h] = t;
      end else begin
        t.v = 1; t.k = addr; t.d = din;
        mq.push_front(t);
        void'(mq.pop_back());
      end
    end
    e_count = 0;
    foreach (mq[i]) if (mq[i].v) e_count++;
    @(posedge CLK);
    #1;
    exp_lvalid = e_lvalid; exp_found = e_found; exp_dout = e_dout;
    exp_idx = e_idx; exp_count = e_count;
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1, 0, 0, a, d, 0, 32'h0);
  endtask

  task automatic look(input logic [31:0] a);
    step(0, 0, 0, 32'h0, 32'h0, 1, a);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("lvalid", 64'(LVALID), 64'(exp_lvalid));
      chk("found", 64'(FOUND), 64'(exp_found));
      chk("dout", 64'(DOUT), 64'(exp_dout));
      chk("hit_idx", 64'(HIT_IDX), 64'(exp_idx));
      chk("count", 64'(COUNT), 64'(exp_count));
      chk("full", 64'(FULL), 64'(exp_count == DEPTH));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_lvalid", 64'(LVALID), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_dout", 64'(DOUT), 64'd0);
    RST = 1'b0;
    chk_en = 1'b1;

    // Address 0 must not hit an empty store.
    look(32'h0);
    chk("addr0_lvalid", 64'(LVALID), 64'd1);
    chk("addr0_found", 64'(FOUND), 64'd0);
    chk("addr0_dout", 64'(DOUT), 64'd0);

    wr(32'h10, 32'hA); wr(32'h20, 32'hB); wr(32'h30, 32'hC);
    look(32'h20);
    chk("l20_found", 64'(FOUND), 64'd1);
    chk("l20_dout", 64'(DOUT), 64'hB);
    chk("l20_idx", 64'(HIT_IDX), 64'd1);
    chk("l20_count", 64'(COUNT), 64'd3);

    wr(32'h20, 32'hEE);
    look(32'h20);
    chk("upd_dout", 64'(DOUT), 64'hEE);
    chk("upd_idx", 64'(HIT_IDX), 64'd1);
    chk("upd_count", 64'(COUNT), 64'd3);
    wr(32'h40, 32'h4); wr(32'h50, 32'h5);
    chk("full_count", 64'(COUNT), 64'd4);
    chk("full_flag", 64'(FULL), 64'd1);
    look(32'h10);
    chk("evict_found", 64'(FOUND), 64'd0);

    // Store: 50,40,30,20. Invalidate 30 leaves a hole at index 2.
    step(0, 1, 0, 32'h30, 32'h0, 0, 32'h0);
    chk("inv_count", 64'(COUNT), 64'd3);
    look(32'h30);
    chk("inv_miss", 64'(FOUND), 64'd0);
    wr(32'h70, 32'h7);
    chk("shift_valid_out", 64'(COUNT), 64'd3);
    wr(32'h80, 32'h8);
    chk("shift_hole_out", 64'(COUNT), 64'd4);

    // Read-before-write on the same edge.
    step(1, 0, 0, 32'h60, 32'h6, 1, 32'h60);
    chk("rbw_found", 64'(FOUND), 64'd0);
    look(32'h60);
    chk("next_found", 64'(FOUND), 64'd1);
    chk("next_dout", 64'(DOUT), 64'h6);
    chk("next_idx", 64'(HIT_IDX), 64'd0);

    step(1, 1, 1, 32'h60, 32'h99, 0, 32'h0);
    chk("flush_count", 64'(COUNT), 64'd0);
    look(32'h60);
    chk("flush_miss", 64'(FOUND), 64'd0);
    look(32'h80);
    idle();
    chk("hold_lvalid", 64'(LVALID), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      bit we, inv, flush, lreq;
      flush = ($urandom_range(0, 99) < 3);
      inv   = ($urandom_range(0, 99) < 15);
      we    = ($urandom_range(0, 99) < 50);
      lreq  = ($urandom_range(0, 99) < 60);
      step(we, inv, flush, 32'($urandom_range(0, 6)), $urandom, lreq,
           32'($urandom_range(0, 6)));
    end

    // Asynchronous reset between edges with a lookup pending.
    wr(32'hAB, 32'h1234);
    look(32'hAB);
    chk("pre_rst_found", 64'(FOUND), 64'd1);
    LREQ = 1'b1; LADDR = 32'hAB;
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("arst_lvalid", 64'(LVALID), 64'd0);
    chk("arst_found", 64'(FOUND), 64'd0);
    chk("arst_dout", 64'(DOUT), 64'd0);
    chk("arst_count", 64'(COUNT), 64'd0);
    @(posedge CLK);
    #1;
    LREQ = 1'b0;
    #2;
    RST = 1'b0;
    idle();
    chk("post_rst_lvalid", 64'(LVALID), 64'd0);
    look(32'hAB);
    chk("post_rst_miss", 64'(FOUND), 64'd0);
    idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
